// File: rtl/spi_master_engine_pkg.sv
// rtl/spi_master_engine_pkg.sv - shared states, widths and edge helper for the SPI master engine
package spi_master_engine_pkg;

    localparam int BYTE_W         = 8;
    localparam int EDGE_W         = 5;
    localparam int WAIT_W         = 4;
    localparam int EDGES_PER_BYTE = 16;
    localparam int DEF_CLK_DIV    = 4;
    localparam int DEF_CS_SETUP   = 2;
    localparam int DEF_CS_HOLD    = 2;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_SETUP = 3'd2,
        ST_SHIFT = 3'd3,
        ST_STORE = 3'd4,
        ST_HOLD  = 3'd5
    } state_t;

    // Returns {shift_mosi, sample_miso} for the SCLK edge about to happen.
    // edge_cnt is the number of edges already completed in this byte.
    // With cpha=1 the first leading edge only "presents" bit7, which is
    // already on MOSI since LOAD, so no shift happens there.
    function automatic logic [1:0] edge_action(input logic             cpha,
                                               input logic             lead,
                                               input logic             trail,
                                               input logic [EDGE_W-1:0] edge_cnt);
        logic shift_en;
        logic sample_en;
        if (cpha) begin
            sample_en = trail;
            shift_en  = lead && (edge_cnt != '0);
        end else begin
            sample_en = lead;
            shift_en  = trail && (edge_cnt != EDGE_W'(EDGES_PER_BYTE - 1));
        end
        return {shift_en, sample_en};
    endfunction

endpackage

// File: rtl/spi_master_engine_if.sv
// rtl/spi_master_engine_if.sv - FIFO and pad signal bundle of the SPI master engine
interface spi_master_engine_if;

    logic       tx_empty;
    logic       tx_rd_en;
    logic [7:0] tx_rd_data;
    logic       rx_full;
    logic       rx_wr_en;
    logic [7:0] rx_wr_data;
    logic       sclk;
    logic       mosi;
    logic       miso;
    logic       cs_n;

    modport master (
        input  tx_empty, tx_rd_data, rx_full, miso,
        output tx_rd_en, rx_wr_en, rx_wr_data, sclk, mosi, cs_n
    );

    modport slave (
        output tx_empty, tx_rd_data, rx_full, miso,
        input  tx_rd_en, rx_wr_en, rx_wr_data, sclk, mosi, cs_n
    );

endinterface

// File: rtl/spi_master_engine_sclk_gen.sv
// rtl/spi_master_engine_sclk_gen.sv - SCLK half-period timer with leading/trailing edge strobes
module spi_master_engine_sclk_gen
    import spi_master_engine_pkg::*;
#(
    parameter int CLK_DIV = DEF_CLK_DIV
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic run_i,
    input  logic cpol_i,
    output logic lead_o,
    output logic trail_o,
    output logic sclk_o
);

    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sclk_q, sclk_d;
    logic             edge_w;

    // An edge fires on the last clk of each half-period; the toggle lands
    // on the same clk edge the strobe is consumed by the engine.
    assign edge_w  = run_i && (cnt_q == CNT_W'(CLK_DIV - 1));
    assign lead_o  = edge_w && (sclk_q == cpol_i);
    assign trail_o = edge_w && (sclk_q != cpol_i);
    assign sclk_o  = sclk_q;

    // Next-state: park at idle level when stopped, otherwise count and toggle
    always_comb begin
        cnt_d  = '0;
        sclk_d = cpol_i;
        if (run_i) begin
            if (edge_w) begin
                cnt_d  = '0;
                sclk_d = ~sclk_q;
            end else begin
                cnt_d  = cnt_q + CNT_W'(1);
                sclk_d = sclk_q;
            end
        end
    end

    // Counter and SCLK registers
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            cnt_q  <= '0;
            sclk_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            sclk_q <= sclk_d;
        end
    end

endmodule

// File: rtl/spi_master_engine.sv
// rtl/spi_master_engine.sv - SPI master shift engine between TX/RX byte FIFOs and the pads
module spi_master_engine
    import spi_master_engine_pkg::*;
#(
    parameter int CLK_DIV  = DEF_CLK_DIV,
    parameter int CS_SETUP = DEF_CS_SETUP,
    parameter int CS_HOLD  = DEF_CS_HOLD
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic enable_i,
    input  logic cpol_i,
    input  logic cpha_i,
    input  logic ovf_clr_i,
    output logic busy_o,
    output logic rx_overflow_o,
    spi_master_engine_if.master bus
);

    state_t              state_q, state_d;
    logic                cpol_q, cpol_d;
    logic                cpha_q, cpha_d;
    logic                cont_q, cont_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic [EDGE_W-1:0]   edge_cnt_q, edge_cnt_d;
    logic [BYTE_W-1:0]   tx_sr_q, tx_sr_d;
    logic [BYTE_W-1:0]   rx_sr_q, rx_sr_d;
    logic                ovf_q, ovf_d;

    logic tx_rd_en_w;
    logic rx_wr_en_w;
    logic tx_avail_w;
    logic cpol_eff_w;
    logic lead_w;
    logic trail_w;
    logic shift_w;
    logic sample_w;
    logic sclk_w;

    // SCLK follows the live cpol input while idle, the latched one in a frame
    assign cpol_eff_w = (state_q == ST_IDLE) ? cpol_i : cpol_q;
    assign tx_avail_w = enable_i && !bus.tx_empty;
    assign {shift_w, sample_w} = edge_action(cpha_q, lead_w, trail_w, edge_cnt_q);

    spi_master_engine_sclk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_sclk_gen (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .run_i   (state_q == ST_SHIFT),
        .cpol_i  (cpol_eff_w),
        .lead_o  (lead_w),
        .trail_o (trail_w),
        .sclk_o  (sclk_w)
    );

    // Strobes are gated by reset so a FIFO never sees a pop/push in a reset cycle
    assign bus.tx_rd_en   = rst_n_i && tx_rd_en_w;
    assign bus.rx_wr_en   = rst_n_i && rx_wr_en_w;
    assign bus.rx_wr_data = rx_sr_q;
    assign bus.sclk       = sclk_w;
    assign bus.mosi       = tx_sr_q[BYTE_W-1];
    assign bus.cs_n       = (state_q == ST_IDLE);
    assign busy_o         = (state_q != ST_IDLE);
    assign rx_overflow_o  = ovf_q;

    // Next-state and strobe decode; the LOAD cycle counts as the first
    // CS setup cycle, so SETUP itself lasts CS_SETUP-1 cycles
    always_comb begin
        state_d    = state_q;
        cpol_d     = cpol_q;
        cpha_d     = cpha_q;
        cont_d     = cont_q;
        wait_d     = '0;
        edge_cnt_d = '0;
        tx_sr_d    = tx_sr_q;
        rx_sr_d    = rx_sr_q;
        ovf_d      = ovf_q;
        tx_rd_en_w = 1'b0;
        rx_wr_en_w = 1'b0;

        if (ovf_clr_i) begin
            ovf_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                cont_d = 1'b0;
                if (tx_avail_w) begin
                    tx_rd_en_w = 1'b1;
                    cpol_d     = cpol_i;
                    cpha_d     = cpha_i;
                    state_d    = ST_LOAD;
                end
            end
            ST_LOAD: begin
                tx_sr_d = bus.tx_rd_data;
                state_d = cont_q ? ST_SHIFT : ST_SETUP;
            end
            ST_SETUP: begin
                if (wait_q == WAIT_W'(CS_SETUP - 2)) begin
                    state_d = ST_SHIFT;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            ST_SHIFT: begin
                edge_cnt_d = edge_cnt_q;
                if (sample_w) begin
                    rx_sr_d = {rx_sr_q[BYTE_W-2:0], bus.miso};
                end
                if (shift_w) begin
                    tx_sr_d = {tx_sr_q[BYTE_W-2:0], 1'b0};
                end
                if (lead_w || trail_w) begin
                    edge_cnt_d = edge_cnt_q + EDGE_W'(1);
                    if (edge_cnt_q == EDGE_W'(EDGES_PER_BYTE - 1)) begin
                        state_d = ST_STORE;
                    end
                end
            end
            ST_STORE: begin
                // A drop sets the flag after the clear above, so set wins
                if (bus.rx_full) begin
                    ovf_d = 1'b1;
                end else begin
                    rx_wr_en_w = 1'b1;
                end
                if (tx_avail_w) begin
                    tx_rd_en_w = 1'b1;
                    cont_d     = 1'b1;
                    state_d    = ST_LOAD;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (wait_q == WAIT_W'(CS_HOLD - 1)) begin
                    state_d = ST_IDLE;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, mode latch, counters, shift registers and overflow flag
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q    <= ST_IDLE;
            cpol_q     <= 1'b0;
            cpha_q     <= 1'b0;
            cont_q     <= 1'b0;
            wait_q     <= '0;
            edge_cnt_q <= '0;
            tx_sr_q    <= '0;
            rx_sr_q    <= '0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cpol_q     <= cpol_d;
            cpha_q     <= cpha_d;
            cont_q     <= cont_d;
            wait_q     <= wait_d;
            edge_cnt_q <= edge_cnt_d;
            tx_sr_q    <= tx_sr_d;
            rx_sr_q    <= rx_sr_d;
            ovf_q      <= ovf_d;
        end
    end

endmodule

// File: tb/tb_spi_master_engine.sv
// tb/tb_spi_master_engine.sv - directed self-checking bench for spi_master_engine
module tb_spi_master_engine;

    logic clk = 1'b0;
    logic rst_n;
    logic enable;
    logic cpol;
    logic cpha;
    logic ovf_clr;
    logic busy;
    logic rx_overflow;

    always #5 clk = ~clk;

    spi_master_engine_if bus();

    spi_master_engine #(
        .CLK_DIV  (4),
        .CS_SETUP (2),
        .CS_HOLD  (2)
    ) dut (
        .clk_i         (clk),
        .rst_n_i       (rst_n),
        .enable_i      (enable),
        .cpol_i        (cpol),
        .cpha_i        (cpha),
        .ovf_clr_i     (ovf_clr),
        .busy_o        (busy),
        .rx_overflow_o (rx_overflow),
        .bus           (bus)
    );

    // TX FIFO model: data appears the cycle after the pop strobe
    logic [7:0] tx_mem [0:31];
    int         tx_wp = 0;
    int         tx_rp = 0;
    assign bus.tx_empty = (tx_wp == tx_rp);
    always @(posedge clk) begin
        if (bus.tx_rd_en) begin
            bus.tx_rd_data <= tx_mem[tx_rp[4:0]];
            tx_rp          <= tx_rp + 1;
        end
    end

    // Monitors
    int         tx_pulses  = 0;
    int         rx_pushes  = 0;
    int         cs_low     = 0;
    int         sclk_rises = 0;
    int         cs_rises   = 0;
    logic [7:0] rx_last    = 8'h00;
    logic [7:0] rx_log [0:63];
    always @(posedge clk) begin
        if (bus.tx_rd_en) tx_pulses++;
        if (bus.rx_wr_en) begin
            rx_log[rx_pushes[5:0]] = bus.rx_wr_data;
            rx_last = bus.rx_wr_data;
            rx_pushes++;
        end
        if (bus.cs_n === 1'b0) cs_low++;
    end
    always @(posedge bus.sclk) sclk_rises++;
    always @(posedge bus.cs_n) cs_rises++;

    // SPI slave model: returns slv_tx, captures MOSI on the mode's sample edges
    logic       loop;
    logic [7:0] slv_tx;
    logic [7:0] slv_sr = 8'h00;
    logic [7:0] slv_rx = 8'h00;
    int         slv_edges = 0;
    logic       prev_cs = 1'b1;
    logic       prev_sclk = 1'b0;
    assign bus.miso = loop ? bus.mosi : slv_sr[7];
    always @(bus.sclk or bus.cs_n) begin
        if (bus.cs_n !== prev_cs) begin
            if (bus.cs_n === 1'b0) begin
                slv_sr    = slv_tx;
                slv_rx    = 8'h00;
                slv_edges = 0;
            end
        end else if (bus.cs_n === 1'b0 && bus.sclk !== prev_sclk) begin
            slv_edges++;
            if ((slv_edges % 2 == 1) != cpha) slv_rx = {slv_rx[6:0], bus.mosi};
            if (cpha ? (slv_edges % 2 == 1 && slv_edges > 1) : (slv_edges % 2 == 0))
                slv_sr = {slv_sr[6:0], 1'b0};
        end
        prev_cs   = bus.cs_n;
        prev_sclk = bus.sclk;
    end

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        tx_mem[tx_wp[4:0]] = b;
        tx_wp++;
    endtask

    // Wait (bounded) for a frame to start and return to idle
    task automatic run_frame(input string tag);
        int n;
        n = 0;
        while (busy !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        while (busy === 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_in_time"}, 32'(n < 2000), 32'd1);
        @(negedge clk);
    endtask

    int tx_b, rx_b, cs_b, sr_b, cr_b;
    task automatic take_base();
        tx_b = tx_pulses;
        rx_b = rx_pushes;
        cs_b = cs_low;
        sr_b = sclk_rises;
        cr_b = cs_rises;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog observed=running expected=finished");
        $fatal(1);
    end

    initial begin
        rst_n       = 1'b0;
        enable      = 1'b1;
        cpol        = 1'b0;
        cpha        = 1'b0;
        ovf_clr     = 1'b0;
        loop        = 1'b1;
        slv_tx      = 8'h00;
        bus.rx_full = 1'b0;
        push(8'hA5);
        repeat (3) @(negedge clk);

        // Reset state, with enable high and TX data waiting
        check("rst_cs_n", bus.cs_n, 1);
        check("rst_sclk", bus.sclk, 0);
        check("rst_mosi", bus.mosi, 0);
        check("rst_busy", busy, 0);
        check("rst_ovf", rx_overflow, 0);
        check("rst_tx_rd_en", bus.tx_rd_en, 0);
        check("rst_rx_wr_en", bus.rx_wr_en, 0);
        check("rst_rx_data", bus.rx_wr_data, 0);
        check("rst_no_pops", tx_pulses, 0);

        // 1: mode 0 loopback of 0xA5
        take_base();
        rst_n = 1'b1;
        run_frame("t1");
        check("t1_pops", tx_pulses - tx_b, 1);
        check("t1_pushes", rx_pushes - rx_b, 1);
        check("t1_rx", rx_last, 8'hA5);
        check("t1_mosi_bits", slv_rx, 8'hA5);
        check("t1_sclk_pulses", sclk_rises - sr_b, 8);
        check("t1_cs_low", cs_low - cs_b, 69);
        check("t1_sclk_idle", bus.sclk, 0);
        enable = 1'b0;

        // 2: modes 1..3, slave returns 0xC3 while master sends 0x3C
        loop   = 1'b0;
        slv_tx = 8'hC3;
        for (int m = 1; m < 4; m++) begin
            cpol = (m >= 2);
            cpha = (m % 2 == 1);
            repeat (3) @(negedge clk);
            check("t2_idle_level", bus.sclk, 32'(cpol));
            take_base();
            push(8'h3C);
            enable = 1'b1;
            run_frame("t2");
            check("t2_rx", rx_last, 8'hC3);
            check("t2_pushes", rx_pushes - rx_b, 1);
            check("t2_slave_rx", slv_rx, 8'h3C);
            check("t2_sclk_pulses", sclk_rises - sr_b, 8);
            check("t2_sclk_end", bus.sclk, 32'(cpol));
            enable = 1'b0;
        end

        // 3: three bytes in one continuous frame
        cpol = 1'b0;
        cpha = 1'b0;
        loop = 1'b1;
        repeat (3) @(negedge clk);
        take_base();
        push(8'h01);
        push(8'h02);
        push(8'h03);
        enable = 1'b1;
        run_frame("t3");
        check("t3_pops", tx_pulses - tx_b, 3);
        check("t3_pushes", rx_pushes - rx_b, 3);
        check("t3_rx0", rx_log[rx_b[5:0]], 8'h01);
        check("t3_rx1", rx_log[6'(rx_b + 1)], 8'h02);
        check("t3_rx2", rx_log[6'(rx_b + 2)], 8'h03);
        check("t3_frames", cs_rises - cr_b, 1);
        check("t3_cs_low", cs_low - cs_b, 201);

        // 4: overflow, clear, and clear coinciding with a new drop
        bus.rx_full = 1'b1;
        take_base();
        push(8'h55);
        run_frame("t4");
        check("t4_no_push", rx_pushes - rx_b, 0);
        check("t4_ovf_set", rx_overflow, 1);
        repeat (5) @(negedge clk);
        check("t4_ovf_sticky", rx_overflow, 1);
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        check("t4_ovf_cleared", rx_overflow, 0);
        push(8'h66);
        repeat (67) @(posedge clk);
        @(negedge clk);
        check("t4_store_busy", busy, 1);
        check("t4_store_no_wr", bus.rx_wr_en, 0);
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        check("t4_set_wins", rx_overflow, 1);
        run_frame("t4b");
        check("t4_no_push_total", rx_pushes - rx_b, 0);
        bus.rx_full = 1'b0;
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        enable  = 1'b0;

        // 5: enable dropped mid-byte with a second byte queued
        push(8'h11);
        push(8'h22);
        take_base();
        enable = 1'b1;
        repeat (22) @(posedge clk);
        @(negedge clk);
        enable = 1'b0;
        run_frame("t5");
        check("t5_pops", tx_pulses - tx_b, 1);
        check("t5_pushes", rx_pushes - rx_b, 1);
        check("t5_rx", rx_last, 8'h11);
        check("t5_cs_low", cs_low - cs_b, 69);
        check("t5_left", tx_wp - tx_rp, 1);
        enable = 1'b1;
        run_frame("t5b");
        check("t5_rx_second", rx_last, 8'h22);
        enable = 1'b0;

        // 6: reset mid-byte, then a fresh frame
        take_base();
        push(8'h77);
        enable = 1'b1;
        repeat (39) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        push(8'h5A);
        @(negedge clk);
        check("t6_cs_n", bus.cs_n, 1);
        check("t6_sclk", bus.sclk, 0);
        check("t6_busy", busy, 0);
        check("t6_rx_data", bus.rx_wr_data, 0);
        check("t6_no_pop", bus.tx_rd_en, 0);
        @(negedge clk);
        check("t6_pops_in_rst", tx_pulses - tx_b, 1);
        check("t6_push_in_rst", rx_pushes - rx_b, 0);
        rst_n = 1'b1;
        run_frame("t6");
        check("t6_rx", rx_last, 8'h5A);
        check("t6_pushes", rx_pushes - rx_b, 1);
        check("t6_pops", tx_pulses - tx_b, 2);
        enable = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
